// File: rtl/traffic_signal_ctrl.sv
// traffic_signal_ctrl
//   Multi-approach traffic-light controller. It cycles GREEN -> YELLOW ->
//   ALLRED for each approach in turn. Empty approaches can be skipped based
//   on vehicle demand, and an emergency vehicle can preempt the sequence.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          run enable; while low, all state holds
//   veh_req     per-approach demand (used only when SKIP_EMPTY=1)
//   emg_req     emergency preemption request (level)
//   emg_dir     approach to preempt to; values >= NUM_DIR are ignored
//   lights      registered lamp codes, 3 bits per approach
//               (100 red, 010 green, 001 yellow)
//   active_dir  approach currently or most recently granted
//   phase       00 ALLRED, 01 GREEN, 10 YELLOW
//   emg_active  high while a preempted green is being held
module traffic_signal_ctrl #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W      = 8,
  parameter int SKIP_EMPTY = 0,
  parameter int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_DIR-1:0]     veh_req,
  input  logic                   emg_req,
  input  logic [DIR_W-1:0]       emg_dir,
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase,
  output logic                   emg_active
);

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]     GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0]     YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0]     ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [DIR_W:0]       NUM_DIR_X = (DIR_W + 1)'(NUM_DIR);
  localparam logic [3*NUM_DIR-1:0] ALL_RED   = {NUM_DIR{3'b100}};

  state_t                 state, state_d;
  logic [CNT_W-1:0]       timer, timer_d;
  logic [DIR_W-1:0]       dir_d;
  logic                   emg_d;
  logic [3*NUM_DIR-1:0]   lights_d;
  logic                   emg_valid;
  logic                   timer_zero;
  logic [DIR_W-1:0]       rr_dir;
  logic [DIR_W-1:0]       skip_dir;
  logic [DIR_W-1:0]       cand;
  logic                   skip_found;
  logic                   grant;

  // (base + step) mod NUM_DIR. The sum needs one extra bit: base < NUM_DIR
  // and step <= NUM_DIR, so the sum never reaches 2*NUM_DIR and one
  // conditional subtract is enough.
  function automatic logic [DIR_W-1:0] wrap_add(input logic [DIR_W-1:0] base,
                                                input logic [DIR_W:0]   step);
    logic [DIR_W:0] sum;
    sum = {1'b0, base} + step;
    if (sum >= NUM_DIR_X) sum = sum - NUM_DIR_X;
    return sum[DIR_W-1:0];
  endfunction

  // An out-of-range emg_dir nullifies the request.
  assign emg_valid  = emg_req && ({1'b0, emg_dir} < NUM_DIR_X);
  assign timer_zero = (timer == '0);
  assign rr_dir     = wrap_add(active_dir, (DIR_W + 1)'(1));
  assign phase      = state;

  // Demand search starts at active_dir+1 and wraps around, so the current
  // approach is considered last.
  always_comb begin
    skip_found = 1'b0;
    skip_dir   = active_dir;
    cand       = '0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = wrap_add(active_dir, k[DIR_W:0]);
      if (!skip_found && veh_req[cand]) begin
        skip_found = 1'b1;
        skip_dir   = cand;
      end
    end
  end

  // Next-state, timer, grant and preemption logic. Lights are computed from
  // the next state so that the registered lamp outputs match phase.
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    dir_d    = active_dir;
    emg_d    = emg_active;
    grant    = 1'b0;
    lights_d = ALL_RED;
    if (en) begin
      case (state)
        GREEN: begin
          // A valid request for this approach holds green with the timer
          // frozen. A request for another approach, or release of a held
          // preemption, cuts green short into a full yellow.
          if (emg_valid && (emg_dir == active_dir)) begin
            emg_d = 1'b1;
          end else if (emg_valid || emg_active) begin
            emg_d   = 1'b0;
            state_d = YELLOW;
            timer_d = YELLOW_LD;
          end else if (timer_zero) begin
            state_d = YELLOW;
            timer_d = YELLOW_LD;
          end else begin
            timer_d = timer - CNT_W'(1);
          end
        end
        YELLOW: begin
          if (timer_zero) begin
            state_d = ALLRED;
            timer_d = ALLRED_LD;
          end else begin
            timer_d = timer - CNT_W'(1);
          end
        end
        ALLRED: begin
          if (!timer_zero) begin
            timer_d = timer - CNT_W'(1);
          end else begin
            // If no approach has demand, hold here with the timer at 0 and
            // retry on every enabled cycle.
            if (emg_valid) begin
              dir_d = emg_dir;
              grant = 1'b1;
            end else if (SKIP_EMPTY == 0) begin
              dir_d = rr_dir;
              grant = 1'b1;
            end else if (skip_found) begin
              dir_d = skip_dir;
              grant = 1'b1;
            end
            if (grant) begin
              state_d = GREEN;
              timer_d = GREEN_LD;
              emg_d   = emg_valid;
            end
          end
        end
        default: begin
          state_d = ALLRED;
          timer_d = ALLRED_LD;
          emg_d   = 1'b0;
        end
      endcase
    end
    for (int i = 0; i < NUM_DIR; i++) begin
      if ((state_d != ALLRED) && (dir_d == i[DIR_W-1:0])) begin
        lights_d[3*i +: 3] = (state_d == GREEN) ? 3'b010 : 3'b001;
      end
    end
  end

  // State register. Reset sets active_dir to the last approach so that the
  // first round-robin grant goes to approach 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ALLRED;
      timer      <= ALLRED_LD;
      active_dir <= DIR_W'(NUM_DIR - 1);
      emg_active <= 1'b0;
      lights     <= ALL_RED;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      active_dir <= dir_d;
      emg_active <= emg_d;
      lights     <= lights_d;
    end
  end

endmodule
